// File: rtl/rs_generic.sv
// Reservation station: CDB wakeup, oldest-ready select into a one-deep issue register.
// Define RS_WAKEUP_BYPASS_EN to let an entry woken this cycle load into the issue register at once.
module rs_generic #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 3,
    parameter int unsigned OP_W    = 4,
    parameter int unsigned NUM_CDB = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             disp_valid,
    output logic                             disp_ready,
    input  logic [OP_W-1:0]                  disp_op,
    input  logic [TAG_W-1:0]                 disp_rob_dest,
    input  logic                             disp_src1_pend,
    input  logic                             disp_src2_pend,
    input  logic [TAG_W-1:0]                 disp_src1_tag,
    input  logic [TAG_W-1:0]                 disp_src2_tag,
    input  logic [DATA_W-1:0]                disp_src1_data,
    input  logic [DATA_W-1:0]                disp_src2_data,
    input  logic [NUM_CDB-1:0]               cdb_valid,
    input  logic [NUM_CDB-1:0][TAG_W-1:0]    cdb_tag,
    input  logic [NUM_CDB-1:0][DATA_W-1:0]   cdb_data,
    output logic                             issue_valid,
    input  logic                             issue_ready,
    output logic [OP_W-1:0]                  issue_op,
    output logic [DATA_W-1:0]                issue_q1,
    output logic [DATA_W-1:0]                issue_q2,
    output logic [TAG_W-1:0]                 issue_rob_dest,
    output logic [$clog2(DEPTH):0]           occupancy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic              hit;
        logic [DATA_W-1:0] data;
    } snoop_t;

    // Lowest-indexed CDB port carrying the tag wins.
    function automatic snoop_t snoop(
        input logic [TAG_W-1:0]                tag,
        input logic [NUM_CDB-1:0]              vld,
        input logic [NUM_CDB-1:0][TAG_W-1:0]   tags,
        input logic [NUM_CDB-1:0][DATA_W-1:0]  data
    );
        snoop_t r;
        r = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (!r.hit && vld[k] && tags[k] == tag) begin
                r.hit  = 1'b1;
                r.data = data[k];
            end
        end
        return r;
    endfunction

    logic [DEPTH-1:0]              valid_q, valid_d;
    logic [DEPTH-1:0]              pend1_q, pend1_d, pend2_q, pend2_d;
    logic [DEPTH-1:0][TAG_W-1:0]   tag1_q, tag1_d, tag2_q, tag2_d;
    logic [DEPTH-1:0][TAG_W-1:0]   dest_q, dest_d;
    logic [DEPTH-1:0][DATA_W-1:0]  val1_q, val1_d, val2_q, val2_d;
    logic [DEPTH-1:0][OP_W-1:0]    op_q, op_d;
    // older_q[i][j] set means entry i was dispatched before entry j.
    logic [DEPTH-1:0][DEPTH-1:0]   older_q, older_d;

    logic                          out_valid_q, out_valid_d;
    logic [OP_W-1:0]               out_op_q;
    logic [DATA_W-1:0]             out_q1_q, out_q2_q;
    logic [TAG_W-1:0]              out_dest_q;

    snoop_t [DEPTH-1:0]            snp1, snp2;
    snoop_t                        dsnp1, dsnp2;
    logic [DEPTH-1:0]              wake1, wake2, rdy1, rdy2, elig;
    logic [DEPTH-1:0][DATA_W-1:0]  opnd1, opnd2;

    logic [DEPTH-1:0]              sel_oh;
    logic                          sel_any;
    logic [OP_W-1:0]               sel_op;
    logic [DATA_W-1:0]             sel_q1, sel_q2;
    logic [TAG_W-1:0]              sel_dest;

    logic [IDX_W-1:0]              free_idx;
    logic                          free_found;
    logic                          load_en, issue_fire, disp_fire;

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + CNT_W'(valid_q[i]);
        end
    end

    assign disp_ready = (occupancy != DEPTH_C);
    assign disp_fire  = disp_valid & disp_ready;
    assign load_en    = ~out_valid_q | issue_ready;
    assign issue_fire = load_en & sel_any;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            snp1[i]  = snoop(tag1_q[i], cdb_valid, cdb_tag, cdb_data);
            snp2[i]  = snoop(tag2_q[i], cdb_valid, cdb_tag, cdb_data);
            wake1[i] = pend1_q[i] & snp1[i].hit;
            wake2[i] = pend2_q[i] & snp2[i].hit;
`ifdef RS_WAKEUP_BYPASS_EN
            rdy1[i]  = ~pend1_q[i] | wake1[i];
            rdy2[i]  = ~pend2_q[i] | wake2[i];
            opnd1[i] = wake1[i] ? snp1[i].data : val1_q[i];
            opnd2[i] = wake2[i] ? snp2[i].data : val2_q[i];
`else
            rdy1[i]  = ~pend1_q[i];
            rdy2[i]  = ~pend2_q[i];
            opnd1[i] = val1_q[i];
            opnd2[i] = val2_q[i];
`endif
            elig[i]  = valid_q[i] & rdy1[i] & rdy2[i];
        end
        dsnp1 = snoop(disp_src1_tag, cdb_valid, cdb_tag, cdb_data);
        dsnp2 = snoop(disp_src2_tag, cdb_valid, cdb_tag, cdb_data);
    end

    // An eligible entry is selected unless some older entry is also eligible.
    always_comb begin
        sel_oh   = '0;
        sel_op   = '0;
        sel_q1   = '0;
        sel_q2   = '0;
        sel_dest = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (elig[i]) begin
                sel_oh[i] = 1'b1;
                for (int j = 0; j < DEPTH; j++) begin
                    if (j != i && elig[j] && older_q[j][i]) begin
                        sel_oh[i] = 1'b0;
                    end
                end
            end
        end
        sel_any = |elig;
        for (int i = 0; i < DEPTH; i++) begin
            sel_op   = sel_op   | (op_q[i]   & {OP_W{sel_oh[i]}});
            sel_q1   = sel_q1   | (opnd1[i]  & {DATA_W{sel_oh[i]}});
            sel_q2   = sel_q2   | (opnd2[i]  & {DATA_W{sel_oh[i]}});
            sel_dest = sel_dest | (dest_q[i] & {TAG_W{sel_oh[i]}});
        end
    end

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!free_found && !valid_q[i]) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        pend1_d = pend1_q & ~wake1;
        pend2_d = pend2_q & ~wake2;
        tag1_d  = tag1_q;
        tag2_d  = tag2_q;
        dest_d  = dest_q;
        op_d    = op_q;
        val1_d  = val1_q;
        val2_d  = val2_q;
        older_d = older_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (wake1[i]) val1_d[i] = snp1[i].data;
            if (wake2[i]) val2_d[i] = snp2[i].data;
        end

        if (issue_fire) begin
            valid_d = valid_d & ~sel_oh;
        end

        if (disp_fire) begin
            valid_d[free_idx] = 1'b1;
            op_d[free_idx]    = disp_op;
            dest_d[free_idx]  = disp_rob_dest;
            tag1_d[free_idx]  = disp_src1_tag;
            tag2_d[free_idx]  = disp_src2_tag;
            pend1_d[free_idx] = disp_src1_pend & ~dsnp1.hit;
            pend2_d[free_idx] = disp_src2_pend & ~dsnp2.hit;
            val1_d[free_idx]  = (disp_src1_pend & dsnp1.hit) ? dsnp1.data : disp_src1_data;
            val2_d[free_idx]  = (disp_src2_pend & dsnp2.hit) ? dsnp2.data : disp_src2_data;
            // Newcomer is younger than every slot; stale bits of free slots get rewritten later.
            older_d[free_idx] = '0;
            for (int j = 0; j < DEPTH; j++) begin
                if (IDX_W'(j) != free_idx) older_d[j][free_idx] = 1'b1;
            end
        end

        if (flush) begin
            valid_d = '0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (load_en) out_valid_d = sel_any;
        if (flush)   out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= '0;
            pend1_q     <= '0;
            pend2_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pend1_q     <= pend1_d;
            pend2_q     <= pend2_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Payload only matters under a valid bit, so it carries no reset.
    always_ff @(posedge clk) begin
        tag1_q  <= tag1_d;
        tag2_q  <= tag2_d;
        dest_q  <= dest_d;
        op_q    <= op_d;
        val1_q  <= val1_d;
        val2_q  <= val2_d;
        older_q <= older_d;
        if (issue_fire) begin
            out_op_q   <= sel_op;
            out_q1_q   <= sel_q1;
            out_q2_q   <= sel_q2;
            out_dest_q <= sel_dest;
        end
    end

    assign issue_valid    = out_valid_q;
    assign issue_op       = out_op_q;
    assign issue_q1       = out_q1_q;
    assign issue_q2       = out_q2_q;
    assign issue_rob_dest = out_dest_q;

    sel_onehot_a: assert property (@(posedge clk) disable iff (!rst) $onehot0(sel_oh));

    issue_hold_a: assert property (@(posedge clk) disable iff (!rst)
        (issue_valid && !issue_ready && !flush) |=>
        (issue_valid && $stable({issue_op, issue_q1, issue_q2, issue_rob_dest})));

endmodule
